// File: rtl/aec_expr_tx.sv
// Expression transmitter: buffers ASCII characters, streams them to a calculator
// followed by '=', then waits (bounded) for the calculator's finish/result.
module aec_expr_tx #(
  parameter int BUFFER_LEN = 64,
  parameter int TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [7:0]  wr_char,
  input  logic        start,
  input  logic        finish,
  input  logic [31:0] result,
  input  logic        valid,
  output logic        ready,
  output logic [7:0]  ascii_out,
  output logic        busy,
  output logic        full,
  output logic [6:0]  count,
  output logic        done,
  output logic [31:0] res_out,
  output logic        res_ok,
  output logic        abort,
  output logic        timeout
);
  // state    | meaning
  // IDLE     | accept writes, wait for start
  // SEND     | stream buffered characters (ready on the first)
  // TERM     | emit '='
  // WAIT_FIN | wait up to TIMEOUT cycles for finish
  // DONE     | one-cycle done pulse, buffer cleared
  localparam int PTR_W = (BUFFER_LEN > 1) ? $clog2(BUFFER_LEN) : 1;
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [6:0]       LEN      = 7'(BUFFER_LEN);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUFFER_LEN - 1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT);
  localparam logic [7:0]       CHAR_EQ  = 8'd61;

  typedef enum logic [2:0] {IDLE, SEND, TERM, WAIT_FIN, DONE} state_t;

  state_t           state;
  logic [7:0]       mem [BUFFER_LEN];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [6:0]       sent;
  logic [TMR_W-1:0] tmr;
  logic             wr_accept;

  // start wins over a simultaneous write
  assign wr_accept = (state == IDLE) && wr_en && !full && !start;

  always_ff @(posedge clk) begin
    if (wr_accept) mem[wr_ptr] <= wr_char;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ready     <= 1'b0;
      ascii_out <= 8'd0;
      busy      <= 1'b0;
      full      <= 1'b0;
      count     <= '0;
      done      <= 1'b0;
      res_out   <= '0;
      res_ok    <= 1'b0;
      abort     <= 1'b0;
      timeout   <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      sent      <= '0;
      tmr       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && count != '0) begin
            state     <= SEND;
            busy      <= 1'b1;
            ready     <= 1'b1;
            ascii_out <= mem[0];
            rd_ptr    <= PTR_W'(1);
            sent      <= 7'd1;
            res_ok    <= 1'b0;
            abort     <= 1'b0;
            timeout   <= 1'b0;
          end else if (wr_accept) begin
            wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
            count  <= count + 7'd1;
            full   <= (count + 7'd1 == LEN);
          end
        end
        SEND: begin
          ready <= 1'b0;
          if (finish) begin
            state     <= DONE;
            done      <= 1'b1;
            abort     <= 1'b1;
            res_out   <= result;
            ascii_out <= 8'd0;
          end else if (sent == count) begin
            state     <= TERM;
            ascii_out <= CHAR_EQ;
          end else begin
            ascii_out <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + PTR_W'(1);
            sent      <= sent + 7'd1;
          end
        end
        TERM: begin
          ascii_out <= 8'd0;
          if (finish) begin
            state   <= DONE;
            done    <= 1'b1;
            res_out <= result;
            res_ok  <= valid;
          end else begin
            state <= WAIT_FIN;
            tmr   <= TMR_LOAD;
          end
        end
        WAIT_FIN: begin
          if (finish) begin
            state   <= DONE;
            done    <= 1'b1;
            res_out <= result;
            res_ok  <= valid;
            tmr     <= '0;
          end else if (tmr > TMR_W'(1)) begin
            tmr <= tmr - TMR_W'(1);
          end else begin
            // res_out deliberately left at its previous value
            state   <= DONE;
            done    <= 1'b1;
            timeout <= 1'b1;
            tmr     <= '0;
          end
        end
        DONE: begin
          state  <= IDLE;
          done   <= 1'b0;
          busy   <= 1'b0;
          count  <= '0;
          full   <= 1'b0;
          wr_ptr <= '0;
          rd_ptr <= '0;
          sent   <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aec_expr_tx.sv
// Directed bench for aec_expr_tx: expected character stream is queued at load
// time and popped as the DUT emits it.
module tb_aec_expr_tx;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_char = 8'd0;
  logic        start = 1'b0;
  logic        finish = 1'b0;
  logic [31:0] result = 32'd0;
  logic        valid = 1'b0;
  logic        ready, busy, full, done, res_ok, abort, timeout;
  logic [7:0]  ascii_out;
  logic [6:0]  count;
  logic [31:0] res_out;

  int         checks = 0;
  int         errors = 0;
  int         exp_count = 0;
  logic [7:0] sb[$];
  string      charset = "0123456789abcdef()*+-";

  aec_expr_tx dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_char(wr_char), .start(start),
    .finish(finish), .result(result), .valid(valid), .ready(ready),
    .ascii_out(ascii_out), .busy(busy), .full(full), .count(count), .done(done),
    .res_out(res_out), .res_ok(res_ok), .abort(abort), .timeout(timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic write_one(input logic [7:0] c, input bit accept);
    wr_en = 1'b1;
    wr_char = c;
    tick();
    wr_en = 1'b0;
    if (accept) begin
      sb.push_back(c);
      exp_count++;
    end
  endtask

  task automatic load(input string s);
    for (int i = 0; i < s.len(); i++) write_one(s[i], 1'b1);
    chk("count_after_load", 32'(count), exp_count);
  endtask

  // fin_at: index in the expected stream at which finish is raised (-1: never)
  task automatic send(input int fin_at, input logic [31:0] res, input logic vld);
    int idx;
    logic [7:0] e;
    idx = 0;
    sb.push_back(8'd61);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", 32'(busy), 1);
    chk("start_clears_abort", 32'(abort), 0);
    chk("start_clears_timeout", 32'(timeout), 0);
    chk("start_clears_res_ok", 32'(res_ok), 0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk("ready", 32'(ready), 32'(idx == 0));
      chk("ascii", 32'(ascii_out), 32'(e));
      if (idx == fin_at) begin
        finish = 1'b1;
        result = res;
        valid = vld;
        tick();
        finish = 1'b0;
        valid = 1'b0;
        sb.delete();
        break;
      end
      tick();
      idx++;
    end
  endtask

  initial begin
    logic seen;
    repeat (3) tick();
    chk("rst_ready", 32'(ready), 0);
    chk("rst_ascii", 32'(ascii_out), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_res_out", res_out, 0);
    chk("rst_flags", {29'd0, res_ok, abort, timeout}, 0);
    rst = 1'b0;
    tick();

    // normal transaction, finish arrives in WAIT_FIN
    load("3+4");
    send(-1, 32'd0, 1'b0);
    chk("t1_wait_busy", 32'(busy), 1);
    chk("t1_wait_ascii", 32'(ascii_out), 0);
    repeat (3) tick();
    finish = 1'b1; result = 32'd7; valid = 1'b1;
    tick();
    finish = 1'b0; valid = 1'b0;
    chk("t1_done", 32'(done), 1);
    chk("t1_res_out", res_out, 7);
    chk("t1_res_ok", 32'(res_ok), 1);
    chk("t1_abort", 32'(abort), 0);
    chk("t1_ascii_done", 32'(ascii_out), 0);
    tick();
    exp_count = 0;
    chk("t1_done_one_cycle", 32'(done), 0);
    chk("t1_count_cleared", 32'(count), 0);
    chk("t1_idle", 32'(busy), 0);
    chk("t1_res_ok_held", 32'(res_ok), 1);

    // finish during SEND on the '+' cycle -> abort, no '='
    load("1+2");
    send(1, 32'd99, 1'b1);
    chk("t2_done", 32'(done), 1);
    chk("t2_abort", 32'(abort), 1);
    chk("t2_res_ok", 32'(res_ok), 0);
    chk("t2_res_out", res_out, 99);
    chk("t2_ascii_zero", 32'(ascii_out), 0);
    chk("t2_ready_zero", 32'(ready), 0);
    tick();
    exp_count = 0;
    chk("t2_done_one_cycle", 32'(done), 0);
    chk("t2_count_cleared", 32'(count), 0);
    chk("t2_abort_held", 32'(abort), 1);

    // timeout; writes while busy must be dropped
    load("5");
    send(-1, 32'd0, 1'b0);
    seen = 1'b0;
    wr_en = 1'b1; wr_char = 8'h66;
    repeat (254) begin
      if (done || timeout) seen = 1'b1;
      tick();
    end
    wr_en = 1'b0;
    chk("t3_no_early_timeout", 32'(seen | done | timeout), 0);
    chk("t3_busy_write_dropped", 32'(count), 1);
    tick();
    chk("t3_done", 32'(done), 1);
    chk("t3_timeout", 32'(timeout), 1);
    chk("t3_res_out_kept", res_out, 99);
    chk("t3_res_ok", 32'(res_ok), 0);
    chk("t3_abort", 32'(abort), 0);
    tick();
    exp_count = 0;
    chk("t3_done_one_cycle", 32'(done), 0);
    chk("t3_count_cleared", 32'(count), 0);

    // empty-buffer start ignored; write with start dropped
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t4_busy", 32'(busy), 0);
    chk("t4_ready", 32'(ready), 0);
    tick();
    chk("t4_busy_later", 32'(busy), 0);
    wr_en = 1'b1; wr_char = 8'h37; start = 1'b1;
    tick();
    wr_en = 1'b0; start = 1'b0;
    chk("t4_write_dropped", 32'(count), 0);
    chk("t4_still_idle", 32'(busy | ready), 0);
    chk("t4_timeout_held", 32'(timeout), 1);

    // full buffer, overflow write dropped, finish on the '=' cycle
    for (int i = 0; i < 64; i++) write_one(charset[i % 21], 1'b1);
    chk("t5_full", 32'(full), 1);
    chk("t5_count64", 32'(count), 64);
    write_one(8'h29, 1'b0);
    chk("t5_overflow_count", 32'(count), 64);
    chk("t5_overflow_full", 32'(full), 1);
    send(64, 32'h1234, 1'b0);
    chk("t5_done", 32'(done), 1);
    chk("t5_res_out", res_out, 32'h1234);
    chk("t5_res_ok", 32'(res_ok), 0);
    chk("t5_abort", 32'(abort), 0);
    tick();
    exp_count = 0;
    chk("t5_count_cleared", 32'(count), 0);
    chk("t5_full_cleared", 32'(full), 0);

    // reset in the middle of SEND
    load("9*a");
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t6_ready", 32'(ready), 1);
    chk("t6_first", 32'(ascii_out), 32'h39);
    tick();
    chk("t6_second", 32'(ascii_out), 32'h2a);
    #2 rst = 1'b1;
    tick();
    chk("t6_rst_ready", 32'(ready), 0);
    chk("t6_rst_ascii", 32'(ascii_out), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_count", 32'(count), 0);
    chk("t6_rst_done", 32'(done), 0);
    rst = 1'b0;
    sb.delete();
    exp_count = 0;
    seen = 1'b0;
    repeat (5) begin
      tick();
      if (done || busy) seen = 1'b1;
    end
    chk("t6_no_done_after_rst", 32'(seen), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
